// File: rtl/clause_table_fetch_sequencer_pkg.sv
// Shared definitions for the clause-table fetch sequencer:
// default sizes and the fetch FSM state encoding.
package sat_defs;

  localparam int NSAT      = 3;
  localparam int LAW       = 12;
  localparam int MC        = 20;
  localparam int NSAT_BITS = $clog2(NSAT);
  localparam int ROW_W     = (NSAT - 1) * MC * LAW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/clause_table_fetch_sequencer_index_valid_pipe.sv
// Shift pipe carrying {valid, flip index} alongside
// outstanding clause-table reads.
module index_valid_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [DEPTH];

  // Shift one stage per cycle; clear drops all in-flight entries.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/clause_table_fetch_sequencer.sv
// Fetches the clause-table rows of the selected clause's literals
// and streams them into the temporal buffers by flip index.
module clause_table_fetch_sequencer #(
  parameter int NSAT                  = sat_defs::NSAT,
  parameter int LITERAL_ADDRESS_WIDTH = sat_defs::LAW,
  parameter int MAX_CLAUSE_MEMBERSHIP = sat_defs::MC,
  parameter int RD_LATENCY            = 1,
  localparam int NSAT_BITS = (NSAT > 1) ? $clog2(NSAT) : 1,
  localparam int ROW_W =
    (NSAT - 1) * MAX_CLAUSE_MEMBERSHIP * LITERAL_ADDRESS_WIDTH
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    start_i,
  input  logic [NSAT*LITERAL_ADDRESS_WIDTH-1:0]   clause_literals_i,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic                                    ct_rd_en_o,
  output logic [LITERAL_ADDRESS_WIDTH-1:0]        ct_rd_addr_o,
  input  logic [ROW_W-1:0]                        ct_rd_data_i,
  output logic [NSAT_BITS-1:0]                    wr_index_o,
  output logic                                    wr_en_o,
  output logic [ROW_W-1:0]                        wr_literals_mo
);
  import sat_defs::*;

  localparam int LW = LITERAL_ADDRESS_WIDTH;
  localparam int NB = NSAT_BITS;
  localparam int DW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  state_e              state;
  logic [NB-1:0]       cnt;
  logic [DW-1:0]       dcnt;
  logic [NSAT*LW-1:0]  lits;
  logic [NB:0]         pipe_in;
  logic [NB:0]         pipe_out;

  // Fetch FSM: capture literals, issue NSAT reads, drain, pulse done.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      cnt          <= '0;
      dcnt         <= '0;
      lits         <= '0;
      ct_rd_en_o   <= 1'b0;
      ct_rd_addr_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state        <= ISSUE;
            cnt          <= '0;
            lits         <= clause_literals_i;
            ct_rd_en_o   <= 1'b1;
            ct_rd_addr_o <= clause_literals_i[LW-1:0];
          end
        end
        ISSUE: begin
          if (cnt == NB'(NSAT - 1)) begin
            state      <= DRAIN;
            cnt        <= '0;
            dcnt       <= '0;
            ct_rd_en_o <= 1'b0;
          end else begin
            cnt          <= cnt + 1'b1;
            ct_rd_addr_o <= lits[LW*(int'(cnt)+1) +: LW];
          end
        end
        DRAIN: begin
          if (dcnt == DW'(RD_LATENCY - 1)) state <= DONE;
          else dcnt <= dcnt + 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign pipe_in = {ct_rd_en_o, ct_rd_en_o ? cnt : NB'(0)};

  index_valid_pipe #(
    .DEPTH (RD_LATENCY),
    .W     (NB + 1)
  ) u_pipe (
    .clk   (clk_i),
    .clr_n (rst_ni),
    .din   (pipe_in),
    .dout  (pipe_out)
  );

  assign busy_o         = (state != IDLE);
  assign done_o         = (state == DONE);
  assign wr_en_o        = pipe_out[NB];
  assign wr_index_o     = pipe_out[NB] ? pipe_out[NB-1:0] : '0;
  assign wr_literals_mo = ct_rd_data_i;

endmodule
